// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard for ID: tracks in-flight destinations, drives forwarding selects
// and the load-use bubble. Define HAZARD_MD_EN to add the multi-cycle multiply/divide stall sequencer.
//   state    | meaning
//   MD_IDLE  | no multi-cycle op in flight
//   MD_BUSY  | op executing, counter runs down to 0, pipeline held
//   MD_DONE  | result ready for one cycle, then back to idle
module hazard_scoreboard #(
  parameter int STAGES     = 2,
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_req_a,
  input  logic [REG_ADDR_W-1:0] id_req_b,
  input  logic                  id_use_a,
  input  logic                  id_use_b,
  input  logic                  id_w_en,
  input  logic [REG_ADDR_W-1:0] id_req_w,
  input  logic                  id_is_load,
  input  logic                  id_is_md,
  input  logic                  flush,
  output logic                  bubble,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic                  md_busy,
  output logic                  md_done
);

  localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  logic [STAGES:1]       vld_q, vld_d, wen_q, wen_d, ld_q, ld_d;
  logic [REG_ADDR_W-1:0] rw_q [1:STAGES];
  logic [REG_ADDR_W-1:0] rw_d [1:STAGES];
  logic [SEL_W-1:0]      sel_a, sel_b;
  logic                  load_use, md_stall, bubble_int, issue;

  // Scan oldest to youngest so the youngest producer overwrites the result.
  function automatic logic [SEL_W-1:0] youngest_match(input logic [REG_ADDR_W-1:0] src,
                                                      input logic use_x);
    youngest_match = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (vld_q[k] && wen_q[k] && (rw_q[k] == src) && (src != '0) && use_x)
        youngest_match = SEL_W'(k);
    end
  endfunction

  always_comb begin
    sel_a    = youngest_match(id_req_a, id_use_a);
    sel_b    = youngest_match(id_req_b, id_use_b);
    load_use = ld_q[1] && ((sel_a == SEL_W'(1)) || (sel_b == SEL_W'(1)));
  end

  assign bubble_int = load_use | md_stall;
  assign issue      = id_valid & ~bubble_int & ~flush;

  always_comb begin
    vld_d = '0;
    wen_d = '0;
    ld_d  = '0;
    for (int k = 1; k <= STAGES; k++) rw_d[k] = '0;
    vld_d[1] = issue;
    wen_d[1] = issue & id_w_en;
    ld_d[1]  = issue & id_is_load;
    rw_d[1]  = issue ? id_req_w : '0;
    for (int k = 2; k <= STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      wen_d[k] = wen_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rw_d[k]  = rw_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      wen_q <= '0;
      ld_q  <= '0;
      for (int k = 1; k <= STAGES; k++) rw_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      wen_q <= wen_d;
      ld_q  <= ld_d;
      rw_q  <= rw_d;
    end
  end

`ifdef HAZARD_MD_EN
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_t;

  md_state_t        md_state_q, md_state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             md_busy_q, md_busy_d, md_done_q, md_done_d;

  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: if (issue && id_is_md) begin
        md_state_d = MD_BUSY;
        md_cnt_d   = CNT_W'(MD_LATENCY - 1);
      end
      MD_BUSY: if (md_cnt_q == '0) md_state_d = MD_DONE;
               else                md_cnt_d   = md_cnt_q - CNT_W'(1);
      MD_DONE: md_state_d = MD_IDLE;
      default: md_state_d = MD_IDLE;
    endcase
    md_busy_d = (md_state_d == MD_BUSY);
    md_done_d = (md_state_d == MD_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= '0;
      md_busy_q  <= 1'b0;
      md_done_q  <= 1'b0;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
      md_busy_q  <= md_busy_d;
      md_done_q  <= md_done_d;
    end
  end

  assign md_stall = md_busy_q;
  assign md_busy  = md_busy_q & ~rst;
  assign md_done  = md_done_q & ~rst;
`else
  logic unused_md_op;
  assign unused_md_op = id_is_md;
  assign md_stall     = 1'b0;
  assign md_busy      = 1'b0;
  assign md_done      = 1'b0;
`endif

  assign bubble    = bubble_int & ~rst;
  assign fwd_sel_a = rst ? '0 : sel_a;
  assign fwd_sel_b = rst ? '0 : sel_b;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: STAGES=2 and STAGES=3 instances share one stimulus stream and are
// checked every cycle against a history-queue model, plus directed literal expectations.
module tb_hazard_scoreboard;
  localparam int MDL = 4;
`ifdef HAZARD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_use_a, id_use_b, id_w_en, id_is_load, id_is_md, flush;
  logic [4:0] id_req_a, id_req_b, id_req_w;
  logic       b2, b3, busy2, busy3, done2, done3;
  logic [1:0] sa2, sb2, sa3, sb3;

  hazard_scoreboard #(.STAGES(2), .REG_ADDR_W(5), .MD_LATENCY(MDL)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_req_a(id_req_a), .id_req_b(id_req_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_w_en(id_w_en), .id_req_w(id_req_w),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .flush(flush), .bubble(b2),
    .fwd_sel_a(sa2), .fwd_sel_b(sb2), .md_busy(busy2), .md_done(done2));

  hazard_scoreboard #(.STAGES(3), .REG_ADDR_W(5), .MD_LATENCY(MDL)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_req_a(id_req_a), .id_req_b(id_req_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_w_en(id_w_en), .id_req_w(id_req_w),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .flush(flush), .bubble(b3),
    .fwd_sel_a(sa3), .fwd_sel_b(sb3), .md_busy(busy3), .md_done(done3));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: hist[0] is the instruction issued most recently (or an empty slot).
  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic [4:0] rw;
  } ent_t;
  ent_t hist [3];
  bit   md_on = 1'b0;
  int   md_start = 0;

  function automatic int m_sel(input logic [4:0] src, input logic use_x, input int depth);
    if (rst || !use_x || src == 5'd0) return 0;
    for (int k = 0; k < depth; k++)
      if (hist[k].v && hist[k].we && hist[k].rw == src) return k + 1;
    return 0;
  endfunction

  function automatic bit m_busy();
    return MD_EN && !rst && md_on && cyc >= md_start + 1 && cyc <= md_start + MDL;
  endfunction

  function automatic bit m_done();
    return MD_EN && !rst && md_on && cyc == md_start + MDL + 1;
  endfunction

  function automatic bit m_bubble();
    bit lu;
    lu = (m_sel(id_req_a, id_use_a, 3) == 1 && hist[0].ld) ||
         (m_sel(id_req_b, id_use_b, 3) == 1 && hist[0].ld);
    return lu || m_busy();
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) hist[k] = '0;
    forever begin
      bit iss;
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k < 3; k++) hist[k] = '0;
        md_on = 1'b0;
      end else begin
        iss = id_valid && !m_bubble() && !flush;
        if (MD_EN && iss && id_is_md && !m_busy() && !m_done()) begin
          md_on    = 1'b1;
          md_start = cyc;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '0;
        if (iss) begin
          hist[0].v  = 1'b1;
          hist[0].we = id_w_en;
          hist[0].ld = id_is_load;
          hist[0].rw = id_req_w;
        end
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      bit eb;
      @(negedge clk);
      if (cmp_en) begin
        eb = m_bubble();
        chk("bubble_s2", int'(b2), int'(eb));
        chk("bubble_s3", int'(b3), int'(eb));
        chk("md_busy_s2", int'(busy2), int'(m_busy()));
        chk("md_busy_s3", int'(busy3), int'(m_busy()));
        chk("md_done_s2", int'(done2), int'(m_done()));
        chk("md_done_s3", int'(done3), int'(m_done()));
        if (!eb) begin
          chk("fwd_a_s2", int'(sa2), m_sel(id_req_a, id_use_a, 2));
          chk("fwd_b_s2", int'(sb2), m_sel(id_req_b, id_use_b, 2));
          chk("fwd_a_s3", int'(sa3), m_sel(id_req_a, id_use_a, 3));
          chk("fwd_b_s3", int'(sb3), m_sel(id_req_b, id_use_b, 3));
        end
      end
    end
  end

  task automatic step(input logic v, input int ra, input int rb, input logic ua, input logic ub,
                      input logic we, input int rw, input logic ld, input logic md,
                      input logic fl, input logic r);
    @(posedge clk);
    #1;
    rst        = r;
    id_valid   = v;
    id_req_a   = 5'(ra);
    id_req_b   = 5'(rb);
    id_use_a   = ua;
    id_use_b   = ub;
    id_w_en    = we;
    id_req_w   = 5'(rw);
    id_is_load = ld;
    id_is_md   = md;
    flush      = fl;
    @(negedge clk);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int rw, input logic ld);
    step(1, 0, 0, 0, 0, 1, rw, ld, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_req_a = '0; id_req_b = '0; id_use_a = 1'b0;
    id_use_b = 1'b0; id_w_en = 1'b0; id_req_w = '0; id_is_load = 1'b0; id_is_md = 1'b0;
    flush = 1'b0;
    cmp_en = 1'b1;

    step(1, 3, 3, 1, 1, 1, 3, 1, 1, 0, 1);
    step(1, 3, 3, 1, 1, 1, 3, 1, 1, 0, 1);
    chk("rst_bubble", int'(b2), 0);
    chk("rst_sel_a", int'(sa2), 0);
    chk("rst_busy", int'(busy2), 0);
    chk("rst_done", int'(done2), 0);

    wr(8, 0);
    step(1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 0);
    chk("fwd1_a", int'(sa2), 1);
    chk("fwd1_b", int'(sb2), 1);
    chk("fwd1_bubble", int'(b2), 0);

    wr(5, 0);
    wr(5, 0);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("youngest_s2", int'(sa2), 1);
    chk("youngest_s3", int'(sa3), 1);
    wr(0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("r0_sel", int'(sa2), 0);

    wr(4, 1);
    step(1, 4, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    chk("lu_bubble", int'(b2), 1);
    chk("lu_model_pin", int'(m_bubble()), 1);
    step(1, 4, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    chk("lu_release", int'(b2), 0);
    chk("lu_fwd_a", int'(sa2), 2);
    chk("lu_fwd_b", int'(sb2), 0);

    wr(4, 1);
    wr(7, 0);
    step(1, 4, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    chk("lu_gap_bubble", int'(b2), 0);
    chk("lu_gap_fwd", int'(sa2), 2);

    wr(10, 0);
    nop();
    nop();
    step(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("depth3_s3", int'(sa3), 3);
    chk("depth3_s2", int'(sa2), 0);
    chk("depth3_model_pin", m_sel(5'd10, 1'b1, 3), 3);
    wr(11, 0);
    nop();
    nop();
    nop();
    step(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("depth4_s3", int'(sa3), 0);

    wr(12, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 12, 12, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_clear_a", int'(sa2), 0);
    chk("rst_clear_b", int'(sb2), 0);

`ifdef HAZARD_MD_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= MDL; i++) begin
      step(1, 3, 0, 1, 0, 1, 13, 0, 0, (i == 2), 0);
      chk("md_busy_seq", int'(busy2), 1);
      chk("md_bubble_seq", int'(b2), 1);
      chk("md_done_early", int'(done2), 0);
    end
    step(1, 3, 0, 1, 0, 1, 13, 0, 0, 0, 0);
    chk("md_done_pulse", int'(done2), 1);
    chk("md_done_busy", int'(busy2), 0);
    chk("md_done_bubble", int'(b2), 0);
    nop();
    chk("md_done_once", int'(done2), 0);

    wr(14, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 14, 14, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("md_rst_busy", int'(busy2), 0);
    chk("md_rst_bubble", int'(b2), 0);
    chk("md_rst_sel", int'(sa3), 0);
    nop();
    chk("md_rst_no_done", int'(done2), 0);
`else
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    nop();
    chk("md_ignored_busy", int'(busy2), 0);
    chk("md_ignored_bubble", int'(b2), 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(7) != 0),
           int'($urandom_range(7)), int'($urandom_range(7)),
           ($urandom_range(3) != 0), ($urandom_range(3) != 0),
           ($urandom_range(3) != 0), int'($urandom_range(7)),
           ($urandom_range(3) == 0), ($urandom_range(11) == 0),
           ($urandom_range(7) == 0), ($urandom_range(63) == 0));
    end

    cmp_en = 1'b0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Sequential hazard and forwarding controller for the pipelined core, placed beside the decode controller in ID. It tracks destination registers of in-flight instructions in a parametrised-depth scoreboard and, from that state, produces per-operand forwarding selects and the load-use bubble. A compile-time option adds a stall sequencer for multi-cycle multiply/divide operations. It replaces the fixed two-stage EX/DM collision inputs with state held inside the block.

## Interface
- STAGES, 2, forwardable stages after ID; stage 1 = EX, stage 2 = DM, up to stage STAGES.
- REG_ADDR_W, 5, register-address width.
- MD_LATENCY, 4, BUSY cycles per multi-cycle op; must be >= 1.
- SEL_W, $clog2(STAGES+1), forwarding-select width (derived).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_req_a / id_req_b  in  REG_ADDR_W  source register numbers.
- id_use_a / id_use_b  in  1  the operand is actually read.
- id_w_en  in  1  the instruction writes the register file.
- id_req_w  in  REG_ADDR_W  destination register number.
- id_is_load  in  1  result available only at the end of stage 2.
- id_is_md  in  1  multi-cycle multiply/divide op; writes HI/LO only.
- flush  in  1  squash the ID instruction (taken branch or jump).
- bubble  out  1  hold PC/IF/ID; insert a NOP into stage 1.
- fwd_sel_a / fwd_sel_b  out  SEL_W  0 = register file, k = forward from stage k.
- md_busy  out  1  multi-cycle unit occupied.
- md_done  out  1  one-cycle pulse when the multi-cycle result is ready.

## Operation
- Scoreboard entry k (1..STAGES) holds {valid, w_en, req_w, is_load}.
- Each edge, entry k <= entry k-1 for k >= 2.
- Entry 1 <= the ID instruction when id_valid & !bubble & !flush; otherwise a cleared entry (bubble).
- A match on entry k requires valid & w_en & req_w == src & src != 0 & use_x.
- fwd_sel_x = the smallest matching k, or 0 if nothing matches. The youngest producer wins.
- Load-use: bubble = 1 when the youngest match for either used operand is entry 1 with is_load = 1. When bubble = 1, fwd_sel is don't-care.
- A load matching at entry k >= 2 forwards normally.
- MD FSM states:
  - IDLE -> BUSY on issue of id_is_md (valid, not bubbled, not flushed). The counter loads MD_LATENCY-1.
  - BUSY: the counter decrements; bubble = 1 while in BUSY. BUSY -> DONE when the counter reaches 0.
  - DONE: md_done = 1, then -> IDLE unconditionally.
- flush does not abort BUSY; the in-flight MD op completes.
- rst clears all entries, sets the FSM to IDLE and the counter to 0.
- While rst = 1, all outputs are forced to 0.

## Timing
- fwd_sel, bubble, md_busy and md_done are combinational from registered state plus current ID inputs. They are valid in the same cycle the instruction sits in ID.
- Load issued at cycle t sits in entry 1 at t+1.
  - A dependent instruction in ID at t+1 sees bubble = 1 for exactly one cycle.
  - At t+2 it sees fwd_sel = 2 and bubble = 0.
- MD op issued at cycle t: md_busy = 1 and bubble = 1 in cycles t+1..t+MD_LATENCY.
- At t+MD_LATENCY+1: md_done = 1, bubble = 0 (unless a load-use hazard exists), md_busy = 0.
- MD_LATENCY = 1: exactly one BUSY cycle.
- Load-use and BUSY together: bubble = 1 (OR of the two causes); the scoreboard still shifts.
- flush with bubble: entry 1 receives a bubble either way.
- rst asserted mid-BUSY: IDLE on the next edge, with no md_done pulse.

## Configuration
- HAZARD_MD_EN defined: the MD FSM, counter, md_busy and md_done are compiled in as specified above.
- HAZARD_MD_EN undefined: id_is_md is ignored, md_busy and md_done are tied to 0, and bubble comes only from load-use. The forwarding and scoreboard logic is unchanged.

## Test plan
- Forwarding from stage 1: STAGES=2. `addu $8,...` then `addu $9,$8,$8` -> fwd_sel_a = fwd_sel_b = 1, bubble = 0.
- Youngest producer wins: two back-to-back writes to $5, then a read of $5 -> fwd_sel_a = 1, not 2. A read of $0 after a write to $0 -> sel = 0.
- Load-use: `lw $4` then `addu $2,$4,$1` -> bubble = 1 for one cycle, then fwd_sel_a = 2. The same pair separated by one unrelated instruction -> no bubble, sel = 2.
- Depth generalisation: STAGES=3. A producer three instructions ahead -> sel = 3; four ahead -> sel = 0.
- MD sequencing (HAZARD_MD_EN, MD_LATENCY=4): issue at t -> bubble and md_busy high for 4 cycles, md_done high at t+5 only. A flush during BUSY leaves the sequence unchanged.
- Reset: rst asserted in the 2nd BUSY cycle -> next cycle md_busy = 0, bubble = 0 and all selects 0. A following read of the previous destination -> sel = 0.
